yarvi_lsu: RTL

YARVI_LSU -- requirements
Module: yarvi_lsu

---
 rtl/yarvi_lsu_pkg.sv | 30 +++
 rtl/yarvi_st_align.sv | 38 +++
 rtl/yarvi_lsu.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/yarvi_lsu_pkg.sv
// Shared definitions for the yarvi load/store unit: data width, funct3 encodings,
// FSM state encoding and the funct3 legality rule.
package yarvi_lsu_pkg;

    localparam int XMSB = 31;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_t;

    // A funct3 is legal if it names one of the RV32 load or store flavours.
    function automatic logic legal_funct3(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return funct3 inside {F3_SB, F3_SH, F3_SW};
        return funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

endpackage

// File: rtl/yarvi_st_align.sv
// Store alignment: byte enables, lane-replicated store data and the
// size-based misalignment flag, all derived from the access size and address.
module yarvi_st_align
    import yarvi_lsu_pkg::*;
(
    input  logic [1:0]    i_size,
    input  logic [1:0]    i_addr_lo,
    input  logic [XMSB:0] i_wdata,
    output logic [3:0]    o_be,
    output logic [XMSB:0] o_wdata,
    output logic          o_misaligned
);

    // Replicating the data lets memory pick whichever lane the enables select.
    always_comb begin
        o_be         = 4'hF;
        o_wdata      = i_wdata;
        o_misaligned = 1'b0;
        case (i_size)
            F3_SB[1:0]: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            F3_SH[1:0]: begin
                o_be         = 4'b0011 << i_addr_lo;
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            F3_SW[1:0]: begin
                o_misaligned = (i_addr_lo != 2'b00);
            end
            default: begin
                o_be = 4'hF;
            end
        endcase
    end

endmodule

// File: rtl/yarvi_lsu.sv
// Load/store unit: accepts one access at a time from execute, drives a simple
// valid/ready memory port and returns load data to the load-alignment stage.
module yarvi_lsu
    import yarvi_lsu_pkg::*;
#(
    parameter bit MISALIGN_CHECK = 1'b1
)
(
    input  logic            clock,
    input  logic            reset,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XMSB:0]   req_addr,
    input  logic [XMSB:0]   req_wdata,
    input  logic [4:0]      req_rd,

    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XMSB-2:0] mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XMSB:0]   mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XMSB:0]   mem_rdata,

    output logic            ld_valid,
    output logic [2:0]      ld_funct3,
    output logic [1:0]      ld_address,
    output logic [XMSB:0]   ld_readdata,
    output logic [4:0]      ld_rd,

    output logic            exc_valid,
    output logic            exc_store,
    output logic [XMSB:0]   exc_addr
);

    lsu_state_t    r_state;
    logic [XMSB:0] r_addr;
    logic [XMSB:0] r_wdata;
    logic [2:0]    r_funct3;
    logic          r_store;
    logic [4:0]    r_rd;
    logic [3:0]    r_be;
    logic          r_mem_valid;
    logic          r_ld_valid;
    logic [2:0]    r_ld_funct3;
    logic [1:0]    r_ld_address;
    logic [XMSB:0] r_ld_readdata;
    logic [4:0]    r_ld_rd;
    logic          r_exc_valid;
    logic          r_exc_store;
    logic [XMSB:0] r_exc_addr;

    logic [3:0]    w_be;
    logic [XMSB:0] w_wdata;
    logic          w_misaligned;
    logic          w_accept;
    logic          w_fault;

    yarvi_st_align u_st_align (
        .i_size       (req_funct3[1:0]),
        .i_addr_lo    (req_addr[1:0]),
        .i_wdata      (req_wdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned)
    );

    assign w_accept = req_valid && (r_state == ST_IDLE);
    assign w_fault  = MISALIGN_CHECK && (w_misaligned || !legal_funct3(req_store, req_funct3));

    // Single FSM; every output below is a register or a decode of the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_funct3      <= '0;
            r_store       <= 1'b0;
            r_rd          <= '0;
            r_be          <= '0;
            r_mem_valid   <= 1'b0;
            r_ld_valid    <= 1'b0;
            r_ld_funct3   <= '0;
            r_ld_address  <= '0;
            r_ld_readdata <= '0;
            r_ld_rd       <= '0;
            r_exc_valid   <= 1'b0;
            r_exc_store   <= 1'b0;
            r_exc_addr    <= '0;
        end else begin
            r_ld_valid  <= 1'b0;
            r_exc_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= req_addr;
                        r_wdata  <= w_wdata;
                        r_funct3 <= req_funct3;
                        r_store  <= req_store;
                        r_rd     <= req_rd;
                        r_be     <= req_store ? w_be : 4'h0;
                        if (w_fault) begin
                            r_exc_valid <= 1'b1;
                            r_exc_store <= req_store;
                            r_exc_addr  <= req_addr;
                        end else begin
                            r_mem_valid <= 1'b1;
                            r_state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= r_store ? ST_IDLE : ST_WAIT;
                    end
                end
                // Responses only count here, so a stray rvalid in the handshake cycle is dropped.
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        r_ld_valid    <= 1'b1;
                        r_ld_readdata <= mem_rdata;
                        r_ld_funct3   <= r_funct3;
                        r_ld_address  <= r_addr[1:0];
                        r_ld_rd       <= r_rd;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_mem_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign mem_valid   = r_mem_valid;
    assign mem_addr    = r_addr[XMSB:2];
    assign mem_we      = r_store;
    assign mem_be      = r_be;
    assign mem_wdata   = r_wdata;
    assign ld_valid    = r_ld_valid;
    assign ld_funct3   = r_ld_funct3;
    assign ld_address  = r_ld_address;
    assign ld_readdata = r_ld_readdata;
    assign ld_rd       = r_ld_rd;
    assign exc_valid   = r_exc_valid;
    assign exc_store   = r_exc_store;
    assign exc_addr    = r_exc_addr;

endmodule
